// File: rtl/csidh_isogeny_scheduler_if.sv
// Command/response bus between the CSIDH exponent scheduler and the
// isogeny engine.
//   master (scheduler): drives cmd_valid, cmd_idx, cmd_dir, cmd_dummy,
//                       cmd_round; samples cmd_ready, rsp_valid, rsp_fail
//   slave  (engine)   : the mirror image
// A command transfers on a cycle with cmd_valid & cmd_ready. rsp_valid is a
// one-cycle pulse closing the accepted command; rsp_fail asks for a retry.
interface csidh_isogeny_scheduler_if #(
  parameter int IDX_W = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_idx;
  logic             cmd_dir;
  logic             cmd_dummy;
  logic [3:0]       cmd_round;
  logic             rsp_valid;
  logic             rsp_fail;

  modport master (
    output cmd_valid, cmd_idx, cmd_dir, cmd_dummy, cmd_round,
    input  cmd_ready, rsp_valid, rsp_fail
  );

  modport slave (
    input  cmd_valid, cmd_idx, cmd_dir, cmd_dummy, cmd_round,
    output cmd_ready, rsp_valid, rsp_fail
  );
endinterface

// File: rtl/csidh_isogeny_scheduler.sv
// Constant-time exponent scheduler for the CSIDH group action.
// Latches a packed private key of NUM_PRIMES signed E_W-bit exponents,
// range-checks every field, then walks rounds 1..MAX_E over every prime
// index issuing one command per (round, prime). A command is a dummy when
// |e_i| < round, so the command stream and its timing never depend on the key.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      one-cycle pulse, honoured only when idle
//   private    packed key, field i = private[i*E_W +: E_W]
//   busy       high whenever not idle
//   done       one-cycle pulse on successful completion
//   key_err    sticky, an exponent is outside -MAX_E..+MAX_E
//   retry_err  sticky, a command failed more than MAX_RETRY times
//   real_cnt   completed non-dummy commands in this run (saturating)
//   eng        command/response bus to the isogeny engine (master side)
module csidh_isogeny_scheduler #(
  parameter int NUM_PRIMES = 130,
  parameter int E_W        = 4,
  parameter int MAX_E      = 5,
  parameter int MAX_RETRY  = 7,
  parameter int IDX_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_PRIMES*E_W-1:0] private,
  output logic                      busy,
  output logic                      done,
  output logic                      key_err,
  output logic                      retry_err,
  output logic [15:0]               real_cnt,
  csidh_isogeny_scheduler_if.master eng
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  // Common width for comparing the (E_W+1)-bit magnitude with the 4-bit round.
  localparam int CMP_W   = E_W + 5;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_PRIMES - 1);
  localparam logic [E_W:0]       MAX_MAG    = (E_W + 1)'(MAX_E);
  localparam logic [E_W-1:0]     MOST_NEG   = {1'b1, {(E_W - 1){1'b0}}};
  localparam logic [3:0]         LAST_ROUND = 4'(MAX_E);
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t                    state_reg;
  logic [NUM_PRIMES*E_W-1:0] key_q;
  logic [IDX_W-1:0]          idx_reg;
  logic [3:0]                round_reg;
  logic [RETRY_W-1:0]        retry_reg;

  // Unpacked view of the latched key, one entry per prime.
  logic [E_W-1:0] key_field [NUM_PRIMES];

  generate
    for (genvar gi = 0; gi < NUM_PRIMES; gi++) begin : g_field
      assign key_field[gi] = key_q[gi*E_W +: E_W];
    end
  endgenerate

  // |e| in E_W+1 bits so that the most negative field does not wrap.
  function automatic logic [E_W:0] mag_of(input logic [E_W-1:0] f);
    logic [E_W:0] s;
    s = {f[E_W-1], f};
    return f[E_W-1] ? (~s + 1'b1) : s;
  endfunction

  logic             last_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic [3:0]       nxt_round;
  logic [IDX_W-1:0] sel_idx;
  logic [3:0]       sel_round;
  logic [E_W-1:0]   sel_field;
  logic [E_W:0]     sel_mag;
  logic             sel_dir;
  logic             sel_dummy;
  logic [E_W-1:0]   chk_field;
  logic [E_W:0]     chk_mag;
  logic             chk_bad;

  // sel_* is the payload of the command about to be loaded into the output
  // registers: (0,1) when leaving CHECK, the advanced position when leaving
  // NEXT. Retries keep the registered payload untouched.
  always_comb begin
    last_idx  = (idx_reg == LAST_IDX);
    nxt_idx   = last_idx ? '0 : idx_reg + 1'b1;
    nxt_round = last_idx ? round_reg + 4'd1 : round_reg;
    sel_idx   = idx_reg;
    sel_round = round_reg;
    if (state_reg == S_CHECK) begin
      sel_idx   = '0;
      sel_round = 4'd1;
    end else if (state_reg == S_NEXT) begin
      sel_idx   = nxt_idx;
      sel_round = nxt_round;
    end
    sel_field = key_field[sel_idx];
    sel_mag   = mag_of(sel_field);
    sel_dir   = sel_field[E_W-1];
    sel_dummy = CMP_W'(sel_mag) < CMP_W'(sel_round);
    chk_field = key_field[idx_reg];
    chk_mag   = mag_of(chk_field);
    chk_bad   = (chk_field == MOST_NEG) || (chk_mag > MAX_MAG);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      key_q         <= '0;
      idx_reg       <= '0;
      round_reg     <= '0;
      retry_reg     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      key_err       <= 1'b0;
      retry_err     <= 1'b0;
      real_cnt      <= '0;
      eng.cmd_valid <= 1'b0;
      eng.cmd_idx   <= '0;
      eng.cmd_dir   <= 1'b0;
      eng.cmd_dummy <= 1'b0;
      eng.cmd_round <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            key_q     <= private;
            key_err   <= 1'b0;
            retry_err <= 1'b0;
            real_cnt  <= '0;
            idx_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (chk_bad) begin
            key_err   <= 1'b1;
            state_reg <= S_FAIL;
          end else if (last_idx) begin
            idx_reg       <= '0;
            round_reg     <= 4'd1;
            retry_reg     <= '0;
            eng.cmd_valid <= 1'b1;
            eng.cmd_idx   <= sel_idx;
            eng.cmd_round <= sel_round;
            eng.cmd_dir   <= sel_dir;
            eng.cmd_dummy <= sel_dummy;
            state_reg     <= S_ISSUE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end

        // Payload registers are only written on entry, so they hold while
        // the engine back-pressures.
        S_ISSUE: begin
          if (eng.cmd_ready) begin
            eng.cmd_valid <= 1'b0;
            state_reg     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (eng.rsp_valid) begin
            if (eng.rsp_fail) begin
              if (retry_reg < RETRY_LIM) begin
                retry_reg     <= retry_reg + 1'b1;
                eng.cmd_valid <= 1'b1;
                state_reg     <= S_ISSUE;
              end else begin
                retry_err <= 1'b1;
                state_reg <= S_FAIL;
              end
            end else begin
              if (!eng.cmd_dummy && (real_cnt != 16'hFFFF)) begin
                real_cnt <= real_cnt + 16'd1;
              end
              retry_reg <= '0;
              state_reg <= S_NEXT;
            end
          end
        end

        S_NEXT: begin
          if (last_idx && (round_reg == LAST_ROUND)) begin
            idx_reg   <= '0;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            idx_reg       <= nxt_idx;
            round_reg     <= nxt_round;
            eng.cmd_valid <= 1'b1;
            eng.cmd_idx   <= sel_idx;
            eng.cmd_round <= sel_round;
            eng.cmd_dir   <= sel_dir;
            eng.cmd_dummy <= sel_dummy;
            state_reg     <= S_ISSUE;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        S_FAIL: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          busy          <= 1'b0;
          done          <= 1'b0;
          eng.cmd_valid <= 1'b0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csidh_isogeny_scheduler.sv
// Directed bench for csidh_isogeny_scheduler: a 4-prime/MAX_E=2 instance,
// the same with MAX_RETRY=2, and the default 130-prime instance. One engine
// task plays the isogeny engine for whichever instance is selected.
module tb_csidh_isogeny_scheduler;

  logic clk;
  logic rst;
  logic start;
  logic cmd_ready;
  logic rsp_valid;
  logic rsp_fail;
  int   sel;

  logic [15:0]  key_s;
  logic [519:0] key_d;

  logic        busy_s, done_s, ke_s, re_s;
  logic        busy_r, done_r, ke_r, re_r;
  logic        busy_d, done_d, ke_d, re_d;
  logic [15:0] rc_s, rc_r, rc_d;

  csidh_isogeny_scheduler_if #(.IDX_W(8)) if_s ();
  csidh_isogeny_scheduler_if #(.IDX_W(8)) if_r ();
  csidh_isogeny_scheduler_if #(.IDX_W(8)) if_d ();

  assign if_s.cmd_ready = cmd_ready;
  assign if_s.rsp_valid = rsp_valid;
  assign if_s.rsp_fail  = rsp_fail;
  assign if_r.cmd_ready = cmd_ready;
  assign if_r.rsp_valid = rsp_valid;
  assign if_r.rsp_fail  = rsp_fail;
  assign if_d.cmd_ready = cmd_ready;
  assign if_d.rsp_valid = rsp_valid;
  assign if_d.rsp_fail  = rsp_fail;

  csidh_isogeny_scheduler #(.NUM_PRIMES(4), .E_W(4), .MAX_E(2), .MAX_RETRY(7), .IDX_W(8)) dut_s (
    .clk(clk), .rst(rst), .start(start && (sel == 0)), .private(key_s),
    .busy(busy_s), .done(done_s), .key_err(ke_s), .retry_err(re_s),
    .real_cnt(rc_s), .eng(if_s)
  );

  csidh_isogeny_scheduler #(.NUM_PRIMES(4), .E_W(4), .MAX_E(2), .MAX_RETRY(2), .IDX_W(8)) dut_r (
    .clk(clk), .rst(rst), .start(start && (sel == 1)), .private(key_s),
    .busy(busy_r), .done(done_r), .key_err(ke_r), .retry_err(re_r),
    .real_cnt(rc_r), .eng(if_r)
  );

  csidh_isogeny_scheduler #(.NUM_PRIMES(130), .E_W(4), .MAX_E(5), .MAX_RETRY(7), .IDX_W(8)) dut_d (
    .clk(clk), .rst(rst), .start(start && (sel == 2)), .private(key_d),
    .busy(busy_d), .done(done_d), .key_err(ke_d), .retry_err(re_d),
    .real_cnt(rc_d), .eng(if_d)
  );

  // Observed outputs of the selected instance.
  logic        o_valid, o_dir, o_dummy, o_busy, o_done, o_ke, o_re;
  logic [7:0]  o_idx;
  logic [3:0]  o_round;
  logic [15:0] o_rc;

  always_comb begin
    case (sel)
      0: begin
        o_valid = if_s.cmd_valid; o_idx = if_s.cmd_idx; o_dir = if_s.cmd_dir;
        o_dummy = if_s.cmd_dummy; o_round = if_s.cmd_round;
        o_busy = busy_s; o_done = done_s; o_ke = ke_s; o_re = re_s; o_rc = rc_s;
      end
      1: begin
        o_valid = if_r.cmd_valid; o_idx = if_r.cmd_idx; o_dir = if_r.cmd_dir;
        o_dummy = if_r.cmd_dummy; o_round = if_r.cmd_round;
        o_busy = busy_r; o_done = done_r; o_ke = ke_r; o_re = re_r; o_rc = rc_r;
      end
      default: begin
        o_valid = if_d.cmd_valid; o_idx = if_d.cmd_idx; o_dir = if_d.cmd_dir;
        o_dummy = if_d.cmd_dummy; o_round = if_d.cmd_round;
        o_busy = busy_d; o_done = done_d; o_ke = ke_d; o_re = re_d; o_rc = rc_d;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  int tr_idx   [1024];
  int tr_round [1024];
  bit tr_dir   [1024];
  bit tr_dummy [1024];
  int z_idx    [1024];
  int z_round  [1024];
  int cyc_zero;

  int ntx;
  int cycles;
  int stall_seen;
  int stab_bad;
  bit got_done;
  bit timed_out;

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Engine model. Called right after pulse_start; runs until done, until busy
  // drops, until stop_at transfers have happened (returning in WAIT), or until
  // the cycle budget expires.
  task automatic run_engine(input int lat, input int stall, input int fidx,
                            input int frnd, input int fn, input int stop_at,
                            input int budget);
    int cd, lidx, lrnd, fdone, st;
    bit cap;
    logic [7:0] c_idx;
    logic [3:0] c_round;
    logic c_dir, c_dummy;
    ntx = 0; cycles = 0; stall_seen = 0; stab_bad = 0;
    got_done = 0; timed_out = 0;
    cd = 0; lidx = -1; lrnd = -1; fdone = 0; st = stall; cap = 0;
    c_idx = '0; c_round = '0; c_dir = 1'b0; c_dummy = 1'b0;
    forever begin
      if (o_done === 1'b1) begin
        got_done = 1;
        break;
      end
      if (o_busy !== 1'b1) break;
      if (cycles >= budget) begin
        timed_out = 1;
        break;
      end
      rsp_valid = 1'b0;
      rsp_fail  = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rsp_valid = 1'b1;
          if (lidx == fidx && lrnd == frnd && fdone < fn) begin
            rsp_fail = 1'b1;
            fdone++;
          end
        end
      end
      cmd_ready = 1'b0;
      if (o_valid === 1'b1) begin
        if (cap) begin
          if (o_idx !== c_idx || o_round !== c_round || o_dir !== c_dir || o_dummy !== c_dummy)
            stab_bad++;
        end else if (st > 0) begin
          c_idx = o_idx; c_round = o_round; c_dir = o_dir; c_dummy = o_dummy;
          cap = 1;
        end
        if (st > 0) begin
          st--;
          stall_seen++;
        end else begin
          cmd_ready = 1'b1;
          cap = 0;
          if (ntx < 1024) begin
            tr_idx[ntx] = int'(o_idx); tr_round[ntx] = int'(o_round);
            tr_dir[ntx] = o_dir; tr_dummy[ntx] = o_dummy;
          end
          if (sel != 2)
            $display("[TB] tx %0d idx=%0d round=%0d dir=%0d dummy=%0d",
                     ntx, o_idx, o_round, o_dir, o_dummy);
          lidx = int'(o_idx); lrnd = int'(o_round);
          ntx++;
          cd = lat;
        end
      end
      if (rsp_valid && cmd_ready) begin
        n_fail++;
        $display("FAIL rsp_same_cycle rsp_valid=1 with transfer, required 0");
      end
      @(negedge clk);
      cycles++;
      if (stop_at != 0 && ntx == stop_at) break;
    end
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_fail  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_fail = 1'b0;
    sel = 0; key_s = '0; key_d = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d want 0", o_busy); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %0d want 0", o_valid); end
    n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0d want 0", o_done); end
    n_tests++; if ({o_ke, o_re} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {o_ke, o_re}); end
    n_tests++; if (o_rc !== 16'd0) begin n_fail++; $display("FAIL reset_real_cnt got %0d want 0", o_rc); end
    sel = 2;
    #1;
    n_tests++; if ({o_busy, o_valid, o_idx, o_round} !== 14'd0) begin n_fail++; $display("FAIL reset_default_outs got %h want 0", {o_busy, o_valid, o_idx, o_round}); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got %0d want 0", o_busy); end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    logic [3:0] d1, d2, dr;
    bit ed;
    d1 = 4'b0100; d2 = 4'b1110; dr = 4'b0010;
    sel = 0; key_s = 16'h10F2;   // fields {+2,-1,0,+1}
    pulse_start();
    run_engine(3, 0, -1, -1, 0, 0, 500);
    n_tests++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
    n_tests++; if (ntx !== 8) begin n_fail++; $display("FAIL basic_ntx got %0d want 8", ntx); end
    for (int k = 0; k < 8; k++) begin
      ed = (k < 4) ? d1[k % 4] : d2[k % 4];
      n_tests++;
      if (tr_idx[k] !== k % 4 || tr_round[k] !== k / 4 + 1 || tr_dummy[k] !== ed || tr_dir[k] !== dr[k % 4]) begin
        n_fail++;
        $display("FAIL basic_cmd%0d got idx=%0d r=%0d dummy=%0d dir=%0d want idx=%0d r=%0d dummy=%0d dir=%0d",
                 k, tr_idx[k], tr_round[k], tr_dummy[k], tr_dir[k], k % 4, k / 4 + 1, ed, dr[k % 4]);
      end
    end
    n_tests++; if (o_rc !== 16'd4) begin n_fail++; $display("FAIL basic_real_cnt got %0d want 4", o_rc); end
    n_tests++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %0d want 1", got_done); end
    @(negedge clk);
    n_tests++; if ({o_done, o_busy} !== 2'b00) begin n_fail++; $display("FAIL basic_done_width got done,busy=%b want 00", {o_done, o_busy}); end
    $display("[TB] basic run: %0d transfers, real_cnt=%0d", ntx, o_rc);
  endtask

  task automatic test_key_err();
    bit seen;
    sel = 0; key_s = 16'h0300;   // field 2 = +3 with MAX_E=2
    pulse_start();
    seen = (o_valid === 1'b1) || (o_done === 1'b1);
    n_tests++; if (o_ke !== 1'b0) begin n_fail++; $display("FAIL keyerr_early got %0d want 0", o_ke); end
    @(negedge clk);
    seen |= (o_valid === 1'b1) || (o_done === 1'b1);
    @(negedge clk);
    seen |= (o_valid === 1'b1) || (o_done === 1'b1);
    n_tests++; if (o_ke !== 1'b0) begin n_fail++; $display("FAIL keyerr_cycle2 got %0d want 0", o_ke); end
    @(negedge clk);
    n_tests++; if ({o_ke, o_busy} !== 2'b11) begin n_fail++; $display("FAIL keyerr_cycle3 got key_err,busy=%b want 11", {o_ke, o_busy}); end
    @(negedge clk);
    n_tests++; if ({o_ke, o_busy} !== 2'b10) begin n_fail++; $display("FAIL keyerr_idle got key_err,busy=%b want 10", {o_ke, o_busy}); end
    repeat (4) begin
      seen |= (o_valid === 1'b1) || (o_done === 1'b1);
      @(negedge clk);
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL keyerr_no_cmd got %0d want 0", seen); end

    key_s = 16'h0008;            // field 0 = -8, the unrepresentable magnitude
    pulse_start();
    n_tests++; if (o_ke !== 1'b0) begin n_fail++; $display("FAIL keyerr_cleared got %0d want 0", o_ke); end
    run_engine(3, 0, -1, -1, 0, 0, 20);
    n_tests++; if ({o_ke, got_done, timed_out} !== 3'b100 || ntx !== 0) begin n_fail++; $display("FAIL keyerr_most_neg got key_err,done,timeout=%b ntx=%0d want 100 ntx=0", {o_ke, got_done, timed_out}, ntx); end

    key_s = 16'hE2E2;            // {+2,-2,+2,-2}: both bounds legal
    pulse_start();
    run_engine(3, 0, -1, -1, 0, 0, 500);
    n_tests++; if ({o_ke, got_done} !== 2'b01 || o_rc !== 16'd8) begin n_fail++; $display("FAIL keyerr_bounds got key_err,done=%b real_cnt=%0d want 01 real_cnt=8", {o_ke, got_done}, o_rc); end
    n_tests++; if ({tr_dir[0], tr_dir[1], tr_dir[7]} !== 3'b011) begin n_fail++; $display("FAIL keyerr_bounds_dir got %b want 011", {tr_dir[0], tr_dir[1], tr_dir[7]}); end
    $display("[TB] key range runs finished");
  endtask

  task automatic test_backpressure();
    sel = 0; key_s = 16'h10F2;
    pulse_start();
    run_engine(3, 5, -1, -1, 0, 0, 500);
    n_tests++; if (stall_seen !== 5) begin n_fail++; $display("FAIL bp_stall got %0d want 5", stall_seen); end
    n_tests++; if (stab_bad !== 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stab_bad); end
    n_tests++; if (ntx !== 8) begin n_fail++; $display("FAIL bp_ntx got %0d want 8", ntx); end
    n_tests++; if (tr_idx[0] !== 0 || tr_round[0] !== 1 || tr_dummy[0] !== 1'b0) begin n_fail++; $display("FAIL bp_first got idx=%0d r=%0d dummy=%0d want 0 1 0", tr_idx[0], tr_round[0], tr_dummy[0]); end
    n_tests++; if (got_done !== 1'b1 || o_rc !== 16'd4) begin n_fail++; $display("FAIL bp_done got done=%0d real_cnt=%0d want 1 4", got_done, o_rc); end
    $display("[TB] backpressure run: %0d stalled cycles, %0d transfers", stall_seen, ntx);
  endtask

  task automatic test_retry();
    int ei [11];
    int er [11];
    ei = '{0, 1, 1, 1, 1, 2, 3, 0, 1, 2, 3};
    er = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2};
    sel = 0; key_s = 16'h10F2;
    pulse_start();
    run_engine(3, 0, 1, 1, 3, 0, 800);
    n_tests++; if (ntx !== 11) begin n_fail++; $display("FAIL retry_ntx got %0d want 11", ntx); end
    for (int k = 0; k < 11; k++) begin
      n_tests++;
      if (tr_idx[k] !== ei[k] || tr_round[k] !== er[k]) begin
        n_fail++;
        $display("FAIL retry_cmd%0d got idx=%0d r=%0d want idx=%0d r=%0d", k, tr_idx[k], tr_round[k], ei[k], er[k]);
      end
    end
    n_tests++; if (o_rc !== 16'd4) begin n_fail++; $display("FAIL retry_real_cnt got %0d want 4", o_rc); end
    n_tests++; if ({got_done, o_re} !== 2'b10) begin n_fail++; $display("FAIL retry_end got done,retry_err=%b want 10", {got_done, o_re}); end
    $display("[TB] retry run: %0d transfers", ntx);
  endtask

  task automatic test_retry_limit();
    sel = 1; key_s = 16'h10F2;
    pulse_start();
    run_engine(3, 0, 1, 1, 3, 0, 800);
    n_tests++; if (ntx !== 4) begin n_fail++; $display("FAIL rlim_ntx got %0d want 4", ntx); end
    n_tests++; if (o_re !== 1'b1) begin n_fail++; $display("FAIL rlim_retry_err got %0d want 1", o_re); end
    n_tests++; if ({got_done, timed_out, o_busy} !== 3'b000) begin n_fail++; $display("FAIL rlim_end got done,timeout,busy=%b want 000", {got_done, timed_out, o_busy}); end
    n_tests++; if (o_rc !== 16'd1) begin n_fail++; $display("FAIL rlim_real_cnt got %0d want 1", o_rc); end
    $display("[TB] retry limit run: %0d transfers, retry_err=%0d", ntx, o_re);
  endtask

  task automatic test_async_reset();
    bit seen;
    sel = 2; key_d = {130{4'h5}};
    pulse_start();
    run_engine(2, 0, -1, -1, 0, 135, 5000);
    n_tests++; if (ntx !== 135 || o_round !== 4'd2 || {o_valid, o_busy} !== 2'b01) begin n_fail++; $display("FAIL areset_setup got ntx=%0d r=%0d valid,busy=%b want 135 2 01", ntx, o_round, {o_valid, o_busy}); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if ({o_busy, o_valid, o_done, o_ke, o_re} !== 5'd0) begin n_fail++; $display("FAIL areset_flags got %b want 00000", {o_busy, o_valid, o_done, o_ke, o_re}); end
    n_tests++; if (o_rc !== 16'd0 || o_idx !== 8'd0 || o_round !== 4'd0) begin n_fail++; $display("FAIL areset_regs got real_cnt=%0d idx=%0d r=%0d want 0 0 0", o_rc, o_idx, o_round); end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen |= (o_done === 1'b1) || (o_busy === 1'b1);
    end
    rst = 1'b1;
    rsp_valid = 1'b1;            // stale response of the aborted command
    @(negedge clk);
    rsp_valid = 1'b0;
    seen |= (o_done === 1'b1) || (o_busy === 1'b1);
    @(negedge clk);
    seen |= (o_done === 1'b1) || (o_busy === 1'b1);
    n_tests++; if (seen !== 1'b0 || o_rc !== 16'd0) begin n_fail++; $display("FAIL areset_quiet got activity=%0d real_cnt=%0d want 0 0", seen, o_rc); end
    $display("[TB] async reset taken in round 2 wait");
  endtask

  task automatic test_full_zero();
    int nd, bad;
    sel = 2; key_d = '0;
    pulse_start();
    run_engine(2, 0, -1, -1, 0, 0, 20000);
    cyc_zero = cycles;
    n_tests++; if (ntx !== 650 || timed_out !== 1'b0) begin n_fail++; $display("FAIL zero_ntx got %0d timeout=%0d want 650 0", ntx, timed_out); end
    nd = 0; bad = 0;
    for (int k = 0; k < 650; k++) begin
      if (tr_dummy[k]) nd++;
      if (tr_idx[k] !== k % 130 || tr_round[k] !== k / 130 + 1) bad++;
      z_idx[k] = tr_idx[k];
      z_round[k] = tr_round[k];
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL zero_order got %0d out of order want 0", bad); end
    n_tests++; if (nd !== 650) begin n_fail++; $display("FAIL zero_dummies got %0d want 650", nd); end
    n_tests++; if (o_rc !== 16'd0 || got_done !== 1'b1) begin n_fail++; $display("FAIL zero_end got real_cnt=%0d done=%0d want 0 1", o_rc, got_done); end
    $display("[TB] all-zero key run: %0d transfers, %0d cycles", ntx, cycles);
  endtask

  task automatic test_timing_equal();
    int nd, bad;
    sel = 2; key_d = {130{4'h5}};
    pulse_start();
    run_engine(2, 0, -1, -1, 0, 0, 20000);
    n_tests++; if (cycles !== cyc_zero) begin n_fail++; $display("FAIL teq_cycles got %0d want %0d", cycles, cyc_zero); end
    n_tests++; if (ntx !== 650) begin n_fail++; $display("FAIL teq_ntx got %0d want 650", ntx); end
    nd = 0; bad = 0;
    for (int k = 0; k < 650; k++) begin
      if (tr_dummy[k]) nd++;
      if (tr_idx[k] !== z_idx[k] || tr_round[k] !== z_round[k]) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL teq_trace got %0d differing commands want 0", bad); end
    n_tests++; if (nd !== 0 || o_rc !== 16'd650) begin n_fail++; $display("FAIL teq_real got dummies=%0d real_cnt=%0d want 0 650", nd, o_rc); end
    $display("[TB] all-+5 key run: %0d transfers, %0d cycles", ntx, cycles);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_key_err();
    test_backpressure();
    test_retry();
    test_retry_limit();
    test_async_reset();
    test_full_zero();
    test_timing_equal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
